// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
//   Handshake/data bundle for the sequential binary-to-BCD converter.
//
//   Signals
//     start  request a conversion of bin (honoured only while busy=0)
//     bin    unsigned binary value, BIN_W bits
//     busy   conversion in progress
//     done   one-cycle pulse: bcd/ovf were updated in this cycle
//     bcd    DIGITS packed BCD digits, digit 0 in bcd[3:0]
//     ovf    value did not fit into DIGITS decimal digits
//
//   Modports
//     master  the requester (drives start/bin)
//     slave   the converter (drives busy/done/bcd/ovf)
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 6
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );

endinterface : bin2bcd_seq_if

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//   Converts one BIN_W-bit value per request, one bit per clock, so a
//   conversion takes BIN_W cycles. The result can optionally have its
//   leading zero digits replaced by 4'hF so a seven-segment driver shows
//   them as blanks.
//
//   Parameters
//     BIN_W     width of the binary input (one shift cycle per bit)
//     DIGITS    number of BCD digits produced (4*DIGITS result bits)
//     LZ_BLANK  1: leading zero digits become 4'hF; 0: raw zeros
//
//   Ports
//     clk_50mhz  system clock, all logic on the rising edge
//     rst        synchronous reset, active high, overrides everything
//     bus        bin2bcd_seq_if slave: start/bin in, busy/done/bcd/ovf out
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 6,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic           clk_50mhz,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Working registers of the double-dabble loop.
  logic [BIN_W-1:0] shreg_q;    // binary bits still to be shifted in
  logic [SCR_W-1:0] scratch_q;  // BCD digits accumulated so far
  logic             carry_q;    // a one fell out of the top digit
  logic [CNT_W-1:0] cnt_q;      // index of the current shift

  // Registered outputs.
  logic [SCR_W-1:0] bcd_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy;

  // Combinational step of the loop.
  logic             accept;
  logic             last_shift;
  logic [SCR_W-1:0] adj;
  logic [SCR_W-1:0] scratch_sh;
  logic [BIN_W-1:0] shreg_sh;
  logic             bit_out;

  // Add 3 to every digit that is 5 or more, so that the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [SCR_W-1:0] add3_digits(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Replace zero digits above the most significant nonzero digit by 4'hF.
  // Digit 0 is left alone so that a zero result still shows one '0'.
  function automatic logic [SCR_W-1:0] blank_lz(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    logic             seen_nz;
    r       = s;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (s[4*i +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end else if (!seen_nz) begin
        r[4*i +: 4] = 4'hF;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Datapath step: adjust, then shift {scratch, shreg} left by one. The
  // bit leaving the top of scratch means the value no longer fits.
  // ---------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first where needed); otherwise a latch is inferred.
  always_comb begin
    adj                             = add3_digits(scratch_q);
    {bit_out, scratch_sh, shreg_sh} = {adj, shreg_q, 1'b0};
  end

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start)  state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. busy drops in the same cycle done rises because the
  // last shift returns the FSM to IDLE on the edge that raises done.
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state_q == S_SHIFT);
  end

  // ---------------------------------------------------------------------
  // Working registers without reset: they are always reloaded on an
  // accepted start before being used, so their reset value is irrelevant.
  // ---------------------------------------------------------------------
  // NOTE: pure datapath storage that is fully initialised before use is
  // deliberately left out of reset; only control state and outputs reset.
  always_ff @(posedge clk_50mhz) begin
    if (accept) begin
      shreg_q   <= bus.bin;
      scratch_q <= '0;
    end else if (state_q == S_SHIFT) begin
      shreg_q   <= shreg_sh;
      scratch_q <= scratch_sh;
    end
  end

  // ---------------------------------------------------------------------
  // Control counters and registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_shift;
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= 1'b0;
      end else if (state_q == S_SHIFT) begin
        cnt_q   <= cnt_q + 1'b1;
        carry_q <= carry_q | bit_out;
        // The result is taken from this cycle's shifted value, so the
        // final shift and the load happen on the same edge.
        if (last_shift) begin
          bcd_q <= LZ_BLANK ? blank_lz(scratch_sh) : scratch_sh;
          ovf_q <= carry_q | bit_out;
        end
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Directed bench for bin2bcd_seq. Three instances:
//     dut_m   BIN_W=16, DIGITS=6, LZ_BLANK=1  (main configuration)
//     dut_nb  BIN_W=16, DIGITS=6, LZ_BLANK=0  (no blanking)
//     dut_d4  BIN_W=16, DIGITS=4, LZ_BLANK=1  (overflow possible)
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int MAX_WAIT = 40;

  logic clk_50mhz;
  logic rst;

  int checks;
  int failures;

  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(6)) bus_m  ();
  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(6)) bus_nb ();
  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(4)) bus_d4 ();

  bin2bcd_seq #(.BIN_W(16), .DIGITS(6), .LZ_BLANK(1'b1)) dut_m (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus_m)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(6), .LZ_BLANK(1'b0)) dut_nb (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus_nb)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .LZ_BLANK(1'b1)) dut_d4 (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus_d4)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct {
    int          sel;      // 0 = dut_m, 1 = dut_nb, 2 = dut_d4
    logic [15:0] bin;
    logic [23:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v, input logic [15:0] b);
    case (sel)
      0:       begin bus_m.start  = v; bus_m.bin  = b; end
      1:       begin bus_nb.start = v; bus_nb.bin = b; end
      default: begin bus_d4.start = v; bus_d4.bin = b; end
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return bus_m.done;
      1:       return bus_nb.done;
      default: return bus_d4.done;
    endcase
  endfunction

  function automatic logic [23:0] bcd_of(input int sel);
    case (sel)
      0:       return bus_m.bcd;
      1:       return bus_nb.bcd;
      default: return {8'h00, bus_d4.bcd};
    endcase
  endfunction

  function automatic logic ovf_of(input int sel);
    case (sel)
      0:       return bus_m.ovf;
      1:       return bus_nb.ovf;
      default: return bus_d4.ovf;
    endcase
  endfunction

  // Pulse start for one cycle and wait (bounded) for done. Called and
  // returns at a falling edge; lat counts rising edges after the accepting
  // edge until done is visible.
  task automatic run_conv(input int sel, input logic [15:0] b,
                          output logic [23:0] got_bcd, output logic got_ovf,
                          output int lat, output bit seen);
    set_start(sel, 1'b1, b);
    @(negedge clk_50mhz);
    set_start(sel, 1'b0, b);
    seen    = 1'b0;
    lat     = 0;
    got_bcd = '0;
    got_ovf = 1'b0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      if (done_of(sel)) begin
        seen    = 1'b1;
        lat     = n - 1;
        got_bcd = bcd_of(sel);
        got_ovf = ovf_of(sel);
        break;
      end
      @(negedge clk_50mhz);
    end
  endtask

  // Wait (bounded) for dut_m done from the current falling edge.
  task automatic wait_done_m(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < MAX_WAIT; n++) begin
      if (bus_m.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_50mhz);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic [23:0] got_bcd;
    logic        got_ovf;
    int          lat;
    bit          seen;
    int          dones;

    checks   = 0;
    failures = 0;

    vecs = '{
      '{0, 16'd0,     24'hFFFFF0, 1'b0},
      '{0, 16'd7,     24'hFFFFF7, 1'b0},
      '{0, 16'd10,    24'hFFFF10, 1'b0},
      '{0, 16'd100,   24'hFFF100, 1'b0},
      '{0, 16'd1000,  24'hFF1000, 1'b0},
      '{0, 16'd10001, 24'hF10001, 1'b0},
      '{0, 16'd40960, 24'hF40960, 1'b0},
      '{0, 16'd65025, 24'hF65025, 1'b0},
      '{0, 16'd65535, 24'hF65535, 1'b0},
      '{1, 16'd100,   24'h000100, 1'b0},
      '{1, 16'd0,     24'h000000, 1'b0},
      '{2, 16'd9999,  24'h009999, 1'b0},
      '{2, 16'd12345, 24'h002345, 1'b1},
      '{2, 16'd10000, 24'h00FFF0, 1'b1},
      '{2, 16'd65535, 24'h005535, 1'b1}
    };

    rst = 1'b1;
    set_start(0, 1'b0, 16'd0);
    set_start(1, 1'b0, 16'd0);
    set_start(2, 1'b0, 16'd0);

    // Reset state after two reset cycles.
    repeat (2) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    check("rst_busy", 32'(bus_m.busy), 32'd0);
    check("rst_done", 32'(bus_m.done), 32'd0);
    check("rst_bcd",  32'(bus_m.bcd),  32'h000000);
    check("rst_ovf",  32'(bus_m.ovf),  32'd0);
    check("rst_bcd_d4", 32'(bus_d4.bcd), 32'h0000);
    rst = 1'b0;
    @(negedge clk_50mhz);

    // Table of single conversions.
    foreach (vecs[i]) begin
      run_conv(vecs[i].sel, vecs[i].bin, got_bcd, got_ovf, lat, seen);
      check($sformatf("v%0d_done", i), 32'(seen),    32'd1);
      check($sformatf("v%0d_lat",  i), 32'(lat),     32'd16);
      check($sformatf("v%0d_bcd",  i), 32'(got_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("v%0d_ovf",  i), 32'(got_ovf), 32'(vecs[i].exp_ovf));
      if (vecs[i].sel == 0) begin
        check($sformatf("v%0d_busy_at_done", i), 32'(bus_m.busy), 32'd0);
      end
      @(negedge clk_50mhz);
      check($sformatf("v%0d_done_pulse", i), 32'(done_of(vecs[i].sel)), 32'd0);
    end

    // Start held during busy with a new value: ignored until the done
    // cycle, then accepted back-to-back.
    set_start(0, 1'b1, 16'd1234);
    @(negedge clk_50mhz);
    check("b2b_busy", 32'(bus_m.busy), 32'd1);
    set_start(0, 1'b1, 16'd9999);
    lat = 1;
    seen = 1'b0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      if (bus_m.done) begin
        seen = 1'b1;
        lat  = n - 1;
        break;
      end
      @(negedge clk_50mhz);
    end
    check("b2b_first_done", 32'(seen),      32'd1);
    check("b2b_first_lat",  32'(lat),       32'd16);
    check("b2b_first_bcd",  32'(bus_m.bcd), 32'hFF1234);
    @(negedge clk_50mhz);
    check("b2b_done_drop", 32'(bus_m.done), 32'd0);
    check("b2b_accepted",  32'(bus_m.busy), 32'd1);
    set_start(0, 1'b0, 16'd0);
    wait_done_m(seen);
    check("b2b_second_done", 32'(seen),      32'd1);
    check("b2b_second_bcd",  32'(bus_m.bcd), 32'hFF9999);
    @(negedge clk_50mhz);

    // Reset in the middle of a conversion.
    set_start(0, 1'b1, 16'd4321);
    @(negedge clk_50mhz);
    set_start(0, 1'b0, 16'd0);
    repeat (7) @(negedge clk_50mhz);
    check("abort_busy_before", 32'(bus_m.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk_50mhz);
    rst = 1'b0;
    check("abort_busy", 32'(bus_m.busy), 32'd0);
    check("abort_done", 32'(bus_m.done), 32'd0);
    check("abort_bcd",  32'(bus_m.bcd),  32'h000000);
    check("abort_ovf",  32'(bus_m.ovf),  32'd0);
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_50mhz);
      if (bus_m.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_conv(0, 16'd7, got_bcd, got_ovf, lat, seen);
    check("after_abort_done", 32'(seen),    32'd1);
    check("after_abort_bcd",  32'(got_bcd), 32'hFFFFF7);
    check("after_abort_ovf",  32'(got_ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bin2bcd_seq
